// File: rtl/sync_fire_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fire_ctrl
//
// Sequencer for one two-source synchronization unit (the Nack-token wait/sync
// stage in front of a two-operand ALU). It accepts a stream configuration,
// drives Active/En_A/En_B into the sync unit, counts synchronized firings and
// issues the Release token on completion, abort or stall-watchdog expiry.
//
// Optional build macro: SYNC_FIRE_PERF_EN
//   defined   -> O_Stall_Cycles is a saturating count of stalled RUN cycles
//   undefined -> O_Stall_Cycles is tied to 0 (the port exists in both builds)
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   I_Cfg_Valid           configuration request
//   I_Cfg_En_A/B          source enables in the configuration
//   I_Cfg_Len             firings in the stream (0 is illegal)
//   I_Cfg_Timeout         stall limit in cycles (0 disables the watchdog)
//   I_Abort               early termination request
//   I_Valid_A/B           valid tokens from the two sources
//   I_Nack_A/B            Nack tokens returned by the sync unit
//   O_Cfg_Ack             configuration accepted (combinational)
//   O_Active, O_En_A/B    registered controls into the sync unit
//   O_Fire                synchronized firing this cycle (combinational)
//   O_Rls                 Release token (one-cycle RELEASE state)
//   O_Done                normal-completion pulse, coincident with O_Rls
//   O_Busy                controller is not IDLE
//   O_Count               firings completed in the current/last stream
//   O_Stall_Err           sticky: watchdog terminated the last stream
//   O_Stall_Cycles        stall performance counter
// -----------------------------------------------------------------------------
module sync_fire_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TO_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Cfg_Valid,
  input  logic                 I_Cfg_En_A,
  input  logic                 I_Cfg_En_B,
  input  logic [CNT_WIDTH-1:0] I_Cfg_Len,
  input  logic [TO_WIDTH-1:0]  I_Cfg_Timeout,
  input  logic                 I_Abort,
  input  logic                 I_Valid_A,
  input  logic                 I_Valid_B,
  input  logic                 I_Nack_A,
  input  logic                 I_Nack_B,
  output logic                 O_Cfg_Ack,
  output logic                 O_Active,
  output logic                 O_En_A,
  output logic                 O_En_B,
  output logic                 O_Fire,
  output logic                 O_Rls,
  output logic                 O_Done,
  output logic                 O_Busy,
  output logic [CNT_WIDTH-1:0] O_Count,
  output logic                 O_Stall_Err,
  output logic [TO_WIDTH-1:0]  O_Stall_Cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CNT_WIDTH-1:0] len_q;
  logic [TO_WIDTH-1:0]  timeout_q;
  logic [TO_WIDTH-1:0]  stall_cnt;
  logic [TO_WIDTH-1:0]  stall_inc;

  logic cfg_legal;
  logic stall_evt;
  logic last_fire;
  logic timeout_hit;

  // Next values of the registered outputs, decoded from next_state.
  logic active_d, en_a_d, en_b_d, rls_d, done_d, busy_d;

  // ---------------------------------------------------------------------------
  // Combinational handshakes and events
  // ---------------------------------------------------------------------------
  assign cfg_legal = (I_Cfg_Len != '0) & (I_Cfg_En_A | I_Cfg_En_B);
  assign O_Cfg_Ack = (state == IDLE) & I_Cfg_Valid & cfg_legal;

  // A disabled source is satisfied only while its valid is low.
  assign O_Fire = O_Active & ~(O_En_A ^ I_Valid_A) & ~(O_En_B ^ I_Valid_B)
                & ~I_Nack_A & ~I_Nack_B;

  assign stall_evt = (state == RUN) & (I_Nack_A | I_Nack_B) & ~O_Fire;
  assign stall_inc = (&stall_cnt) ? stall_cnt : stall_cnt + 1'b1;

  // len_q is never 0 while RUN, so len_q-1 cannot underflow in use.
  assign last_fire = O_Fire & (O_Count == len_q - 1'b1);

  // The watchdog compares against the value the stall counter is about to
  // take, so Timeout=N terminates on the N-th consecutive stalled cycle.
  assign timeout_hit = stall_evt & (timeout_q != '0) & (stall_inc == timeout_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (priority: last fire > abort > timeout)
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (O_Cfg_Ack) next_state = RUN;
      RUN:     if (last_fire | I_Abort | timeout_hit) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (values registered on the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    active_d = (next_state == RUN);
    en_a_d   = 1'b0;
    en_b_d   = 1'b0;
    if (next_state == RUN) begin
      en_a_d = (state == IDLE) ? I_Cfg_En_A : O_En_A;
      en_b_d = (state == IDLE) ? I_Cfg_En_B : O_En_B;
    end
    rls_d  = (next_state == RELEASE);
    // Last fire wins over abort/timeout, so Done marks normal completion only.
    done_d = (state == RUN) & last_fire;
    busy_d = (next_state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      O_Active    <= 1'b0;
      O_En_A      <= 1'b0;
      O_En_B      <= 1'b0;
      O_Rls       <= 1'b0;
      O_Done      <= 1'b0;
      O_Busy      <= 1'b0;
      O_Count     <= '0;
      O_Stall_Err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      O_Active <= active_d;
      O_En_A   <= en_a_d;
      O_En_B   <= en_b_d;
      O_Rls    <= rls_d;
      O_Done   <= done_d;
      O_Busy   <= busy_d;

      if (O_Cfg_Ack) begin
        O_Count     <= '0;
        O_Stall_Err <= 1'b0;
        stall_cnt   <= '0;
      end else if (state == RUN) begin
        if (O_Fire) begin
          O_Count   <= O_Count + 1'b1;
          stall_cnt <= '0;
        end else if (stall_evt) begin
          stall_cnt <= stall_inc;
        end
        if (timeout_hit & ~I_Abort) O_Stall_Err <= 1'b1;
      end
    end
  end

  // NOTE: the configuration holding registers carry no reset; they are only
  // read in RUN, which is reachable solely through an ack that loads them.
  always_ff @(posedge clock) begin
    if (O_Cfg_Ack) begin
      len_q     <= I_Cfg_Len;
      timeout_q <= I_Cfg_Timeout;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stall performance counter
  // ---------------------------------------------------------------------------
`ifdef SYNC_FIRE_PERF_EN
  logic [TO_WIDTH-1:0] perf_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cnt <= '0;
    end else if (O_Cfg_Ack) begin
      perf_cnt <= '0;
    end else if (stall_evt & ~(&perf_cnt)) begin
      perf_cnt <= perf_cnt + 1'b1;
    end
  end

  assign O_Stall_Cycles = perf_cnt;
`else
  assign O_Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_sync_fire_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fire_ctrl
//
// Self-checking bench for sync_fire_ctrl. Inputs are applied on the falling
// edge; one nanosecond later the combinational outputs and the registered
// outputs are compared against a stream-level reference model, which is then
// advanced on the rising edge. Directed scenarios come first, followed by a
// randomized run.
// -----------------------------------------------------------------------------
module tb_sync_fire_ctrl;

  localparam int CW   = 16;
  localparam int TW   = 8;
  localparam int TMAX = (1 << TW) - 1;

  logic          clock;
  logic          reset;
  logic          cfg_valid, cfg_en_a, cfg_en_b;
  logic [CW-1:0] cfg_len;
  logic [TW-1:0] cfg_timeout;
  logic          abort, valid_a, valid_b, nack_a, nack_b;
  logic          cfg_ack, active, en_a, en_b, fire, rls, done, busy, stall_err;
  logic [CW-1:0] count;
  logic [TW-1:0] stall_cycles;

  sync_fire_ctrl #(.CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
    .clock         (clock),
    .reset         (reset),
    .I_Cfg_Valid   (cfg_valid),
    .I_Cfg_En_A    (cfg_en_a),
    .I_Cfg_En_B    (cfg_en_b),
    .I_Cfg_Len     (cfg_len),
    .I_Cfg_Timeout (cfg_timeout),
    .I_Abort       (abort),
    .I_Valid_A     (valid_a),
    .I_Valid_B     (valid_b),
    .I_Nack_A      (nack_a),
    .I_Nack_B      (nack_b),
    .O_Cfg_Ack     (cfg_ack),
    .O_Active      (active),
    .O_En_A        (en_a),
    .O_En_B        (en_b),
    .O_Fire        (fire),
    .O_Rls         (rls),
    .O_Done        (done),
    .O_Busy        (busy),
    .O_Count       (count),
    .O_Stall_Err   (stall_err),
    .O_Stall_Cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a stream is idle, running or releasing; counts are ints.
  // ---------------------------------------------------------------------------
  typedef enum int {P_IDLE, P_RUN, P_REL} phase_t;

  phase_t m_phase;
  bit     m_valid = 1'b0;
  bit     m_active, m_en_a, m_en_b, m_rls, m_done, m_busy, m_err;
  int     m_len, m_to, m_count, m_stall, m_perf;

  function automatic int sat(input int v);
    return (v > TMAX) ? TMAX : v;
  endfunction

  // Apply one cycle of inputs, compare, then advance the model on the edge.
  task automatic step(input bit rst, input bit cv, input bit cea, input bit ceb,
                      input int clen, input int cto, input bit ab,
                      input bit va, input bit vb, input bit na, input bit nb);
    bit exp_ack, exp_fire, stall_ev, finished, timed;
    reset       = rst;
    cfg_valid   = cv;
    cfg_en_a    = cea;
    cfg_en_b    = ceb;
    cfg_len     = CW'(clen);
    cfg_timeout = TW'(cto);
    abort       = ab;
    valid_a     = va;
    valid_b     = vb;
    nack_a      = na;
    nack_b      = nb;
    #1;
    exp_ack  = (m_phase == P_IDLE) && cv && (clen != 0) && (cea || ceb);
    exp_fire = m_active && (m_en_a == va) && (m_en_b == vb) && !na && !nb;
    if (m_valid) begin
      check("ack",   32'(cfg_ack), 32'(exp_ack));
      check("fire",  32'(fire),    32'(exp_fire));
      check("flags", 32'({active, en_a, en_b, rls, done, busy, stall_err}),
                     32'({m_active, m_en_a, m_en_b, m_rls, m_done, m_busy, m_err}));
      check("count", 32'(count), 32'(m_count));
`ifdef SYNC_FIRE_PERF_EN
      check("perf",  32'(stall_cycles), 32'(m_perf));
`else
      check("perf",  32'(stall_cycles), 32'd0);
`endif
    end
    @(posedge clock);
    if (rst) begin
      m_phase = P_IDLE;
      {m_active, m_en_a, m_en_b, m_rls, m_done, m_busy, m_err} = '0;
      m_count = 0; m_stall = 0; m_perf = 0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE: begin
          m_rls = 0; m_done = 0;
          if (exp_ack) begin
            m_len = clen; m_to = cto;
            m_count = 0; m_stall = 0; m_err = 0; m_perf = 0;
            m_en_a = cea; m_en_b = ceb; m_active = 1; m_busy = 1;
            m_phase = P_RUN;
          end
        end
        P_RUN: begin
          stall_ev = (na || nb) && !exp_fire;
          if (exp_fire) m_count++;
          if (exp_fire)      m_stall = 0;
          else if (stall_ev) m_stall = sat(m_stall + 1);
          if (stall_ev) m_perf = sat(m_perf + 1);
          finished = exp_fire && (m_count == m_len);
          timed    = (m_to != 0) && stall_ev && (m_stall == m_to);
          if (finished || ab || timed) begin
            m_phase = P_REL;
            m_active = 0; m_en_a = 0; m_en_b = 0;
            m_rls = 1; m_done = finished;
            if (timed && !finished && !ab) m_err = 1;
          end
        end
        default: begin
          m_rls = 0; m_done = 0; m_busy = 0;
          m_phase = P_IDLE;
        end
      endcase
    end
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input bit ea, input bit eb, input int len, input int to);
    step(0, 1, ea, eb, len, to, 0, 0, 0, 0, 0);
  endtask

  task automatic run(input bit va, input bit vb, input bit na, input bit nb,
                     input bit ab);
    step(0, 0, 0, 0, 0, 0, ab, va, vb, na, nb);
  endtask

  initial begin
    m_phase = P_IDLE;
    {reset, cfg_valid, cfg_en_a, cfg_en_b, abort} = '0;
    {valid_a, valid_b, nack_a, nack_b} = '0;
    cfg_len = '0; cfg_timeout = '0;
    @(negedge clock);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_flags", 32'({active, en_a, en_b, rls, done, busy, stall_err}), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // 1: both sources, Len=3, three clean firings
    cfg(1, 1, 3, 0);
    repeat (3) run(1, 1, 0, 0, 0);
    check("t1_rls",   32'(rls),   32'd1);
    check("t1_done",  32'(done),  32'd1);
    check("t1_count", 32'(count), 32'd3);
    idle();
    check("t1_busy",  32'(busy),      32'd0);
    check("t1_err",   32'(stall_err), 32'd0);

    // 2: only A enabled; B valid blocks a fire for one cycle
    cfg(1, 0, 2, 0);
    run(1, 1, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    check("t2_count", 32'(count), 32'd2);
    check("t2_done",  32'(done),  32'd1);
    idle();

    // 3: watchdog, Timeout=4 with Nack_A held
    cfg(1, 1, 5, 4);
    repeat (4) run(1, 1, 1, 0, 0);
    check("t3_rls",   32'(rls),       32'd1);
    check("t3_err",   32'(stall_err), 32'd1);
    check("t3_done",  32'(done),      32'd0);
    check("t3_count", 32'(count),     32'd0);
`ifdef SYNC_FIRE_PERF_EN
    check("t3_perf",  32'(stall_cycles), 32'd4);
`endif
    idle();

    // 4a: abort after two fires
    cfg(1, 1, 4, 0);
    repeat (2) run(1, 1, 0, 0, 0);
    run(0, 0, 0, 0, 1);
    check("t4a_rls",   32'(rls),   32'd1);
    check("t4a_done",  32'(done),  32'd0);
    check("t4a_count", 32'(count), 32'd2);
    idle();
    // 4b: abort together with the last fire
    cfg(1, 1, 4, 0);
    repeat (3) run(1, 1, 0, 0, 0);
    run(1, 1, 0, 0, 1);
    check("t4b_done",  32'(done),  32'd1);
    check("t4b_count", 32'(count), 32'd4);
    idle();

    // 5: illegal configurations and a configuration while running
    cfg(1, 1, 0, 0);
    cfg(0, 0, 3, 0);
    check("t5_busy_idle", 32'(busy), 32'd0);
    cfg(1, 1, 3, 0);
    cfg(0, 1, 7, 2);
    check("t5_en_a", 32'(en_a), 32'd1);
    run(0, 0, 0, 0, 1);
    idle();

    // 6: reset mid-stream, then a fresh configuration
    cfg(1, 1, 5, 0);
    run(1, 1, 0, 0, 0);
    check("t6_count_pre", 32'(count), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("t6_flags", 32'({active, en_a, en_b, rls, done, busy, stall_err}), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    cfg(0, 1, 2, 0);
    check("t6_busy", 32'(busy), 32'd1);

    // Randomized run, biased so that streams make progress
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_cv, r_ea, r_eb, r_ab, r_va, r_vb, r_na, r_nb;
      int r_len, r_to;
      r_rst = ($urandom_range(0, 299) == 0);
      r_cv  = ($urandom_range(0, 3) == 0);
      r_ea  = 1'($urandom_range(0, 1));
      r_eb  = 1'($urandom_range(0, 1));
      r_len = $urandom_range(0, 6);
      r_to  = $urandom_range(0, 5);
      r_ab  = ($urandom_range(0, 29) == 0);
      r_va  = ($urandom_range(0, 3) != 0) ? m_en_a : 1'($urandom_range(0, 1));
      r_vb  = ($urandom_range(0, 3) != 0) ? m_en_b : 1'($urandom_range(0, 1));
      r_na  = ($urandom_range(0, 4) == 0);
      r_nb  = ($urandom_range(0, 4) == 0);
      step(r_rst, r_cv, r_ea, r_eb, r_len, r_to, r_ab, r_va, r_vb, r_na, r_nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
